// File: rtl/fiforam_rdctl.sv
// Control sequencer for the shared FIFO-RAM line buffer: accepts upstream entries
// and replays a sliding window of them cfg_pass times per slide.
module fiforam_rdctl #(
    parameter int Size   = 12,
    parameter int AWd    = $clog2(Size),
    parameter int PassWd = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [AWd:0]      i_cfg_win,
    input  logic [PassWd-1:0] i_cfg_pass,
    input  logic [PassWd-1:0] i_cfg_slides,
    output logic              o_busy,
    output logic              o_done,
    input  logic              i_in_rdy,
    input  logic              i_in_dup,
    output logic              o_in_ack,
    output logic              o_write,
    output logic              o_dupWrite,
    output logic              o_read,
    output logic              o_pop,
    output logic              o_lastpix,
    input  logic              i_dn_hold
);
    // Wide enough for win + slides - 1 at the maximum of both fields.
    localparam int CntWd = PassWd + AWd + 1;
    localparam logic [AWd:0] SizeW = (AWd+1)'(Size);

    typedef enum logic [1:0] {IDLE, FILL, READ, DONE} state_t;

    state_t            state, state_n;
    logic [AWd:0]      win_q;
    logic [PassWd-1:0] pass_q, slides_q;
    logic [AWd:0]      occ, occ_n;
    logic [CntWd-1:0]  wcnt, nt;
    logic [AWd:0]      idx, idx_n;
    logic [PassWd-1:0] pass_cnt, pass_n;
    logic [PassWd-1:0] slide_cnt, slide_n;
    logic              start_ok;

    assign nt       = CntWd'(win_q) + CntWd'(slides_q) - 1'b1;
    assign o_busy   = (state != IDLE);
    assign start_ok = (state == IDLE) && i_start;

    // Write side runs independently of the read FSM; a slot freed by a pop
    // this cycle only becomes usable next cycle because occ is registered.
    assign o_in_ack   = o_busy && i_in_rdy && (occ < SizeW) && (wcnt < nt);
    assign o_write    = o_in_ack && !i_in_dup;
    assign o_dupWrite = o_in_ack && i_in_dup;

    assign occ_n = occ + (AWd+1)'(o_in_ack) - (AWd+1)'(o_pop);

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        pass_n    = pass_cnt;
        slide_n   = slide_cnt;
        o_read    = 1'b0;
        o_lastpix = 1'b0;
        o_pop     = 1'b0;
        o_done    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_n = FILL;
                    slide_n = '0;
                end
            end
            FILL: begin
                if (occ >= win_q) begin
                    state_n = READ;
                    idx_n   = '0;
                    pass_n  = '0;
                end
            end
            READ: begin
                if (!i_dn_hold) begin
                    o_read = 1'b1;
                    if (idx == win_q - 1'b1) begin
                        // Window end: lastpix rewinds the buffer; the final pass also pops.
                        o_lastpix = 1'b1;
                        idx_n     = '0;
                        if (pass_cnt == pass_q - 1'b1) begin
                            o_pop = 1'b1;
                            if (slide_cnt == slides_q - 1'b1) begin
                                state_n = DONE;
                            end else begin
                                slide_n = slide_cnt + 1'b1;
                                state_n = FILL;
                            end
                        end else begin
                            pass_n = pass_cnt + 1'b1;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            win_q     <= '0;
            pass_q    <= '0;
            slides_q  <= '0;
            occ       <= '0;
            wcnt      <= '0;
            idx       <= '0;
            pass_cnt  <= '0;
            slide_cnt <= '0;
        end else begin
            state     <= state_n;
            occ       <= occ_n;
            idx       <= idx_n;
            pass_cnt  <= pass_n;
            slide_cnt <= slide_n;
            if (start_ok) begin
                win_q    <= i_cfg_win;
                pass_q   <= i_cfg_pass;
                slides_q <= i_cfg_slides;
                wcnt     <= '0;
            end else if (o_in_ack) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fiforam_rdctl.sv
// Directed bench for fiforam_rdctl: runs small jobs and compares read/pop/ack
// patterns and timing against hand-computed sequences.
module tb_fiforam_rdctl;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [4:0] i_cfg_win = '0;
    logic [7:0] i_cfg_pass = '0;
    logic [7:0] i_cfg_slides = '0;
    logic       i_in_rdy = 1'b1;
    logic       i_in_dup;
    logic       i_dn_hold = 1'b0;
    logic       o_busy, o_done, o_in_ack, o_write, o_dupWrite, o_read, o_pop, o_lastpix;

    fiforam_rdctl #(.Size(12), .PassWd(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_cfg_win(i_cfg_win), .i_cfg_pass(i_cfg_pass), .i_cfg_slides(i_cfg_slides),
        .o_busy(o_busy), .o_done(o_done),
        .i_in_rdy(i_in_rdy), .i_in_dup(i_in_dup), .o_in_ack(o_in_ack),
        .o_write(o_write), .o_dupWrite(o_dupWrite), .o_read(o_read),
        .o_pop(o_pop), .o_lastpix(o_lastpix), .i_dn_hold(i_dn_hold)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ent = 0;
    logic [31:0] dup_mask = '0;

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (i_rst) ent <= 0;
        else if (o_in_ack) ent <= ent + 1;
    end
    assign i_in_dup = dup_mask[ent[4:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor logs: only this process appends; stimulus snapshots bases per job.
    logic [1:0] rd_log[$];
    int rd_cyc[$];
    int ack_cyc[$];
    int pop_cyc[$];
    int wr_cnt = 0;
    int dup_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    always @(negedge i_clk) begin
        check("ctl_wo_read", (o_pop | o_lastpix) & ~o_read, 0);
        check("read_in_hold", o_read & i_dn_hold, 0);
        if (o_in_ack) begin
            check("wr_xor_dup", o_write ^ o_dupWrite, 1);
            check("dup_sel", o_dupWrite, dup_mask[ent[4:0]]);
            ack_cyc.push_back(cyc);
            wr_cnt  += int'(o_write);
            dup_cnt += int'(o_dupWrite);
        end else begin
            check("wr_wo_ack", o_write | o_dupWrite, 0);
        end
        if (o_read) begin
            rd_log.push_back({o_lastpix, o_pop});
            rd_cyc.push_back(cyc);
        end
        if (o_pop) pop_cyc.push_back(cyc);
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int rd_b, ack_b, pop_b, wr_b, dup_b, done_b;
    logic [1:0] exp_q[$];

    task automatic do_reset();
        i_rst = 1'b1;
        i_start = 1'b0;
        i_dn_hold = 1'b0;
        dup_mask = '0;
        repeat (2) begin @(posedge i_clk); #1; end
        i_rst = 1'b0;
    endtask

    task automatic start_job(input int w, input int p, input int s);
        rd_b = rd_log.size(); ack_b = ack_cyc.size(); pop_b = pop_cyc.size();
        wr_b = wr_cnt; dup_b = dup_cnt; done_b = done_cnt;
        i_cfg_win = 5'(w); i_cfg_pass = 8'(p); i_cfg_slides = 8'(s);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > done_b) break;
            @(posedge i_clk); #1;
        end
        check("done_seen", done_cnt - done_b, 1);
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 200; i++) begin
            if (rd_log.size() - rd_b >= n) break;
            @(posedge i_clk); #1;
        end
        check("reads_reached", rd_log.size() - rd_b, n);
    endtask

    task automatic check_reads();
        int n;
        n = rd_log.size() - rd_b;
        check("rd_len", n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < n) check("rd_seq", rd_log[rd_b + i], exp_q[i]);
    endtask

    initial begin
        // Reset state
        do_reset();
        #4;
        check("rst_outputs", {o_busy, o_done, o_read, o_pop, o_lastpix, o_write, o_dupWrite, o_in_ack}, 0);
        check("rst_occ", dut.occ, 0);

        // 1: win=3 pass=1 slides=2
        start_job(3, 1, 2);
        check("busy_after_start", o_busy, 1);
        wait_done();
        exp_q = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
        check_reads();
        check("t1_writes", wr_cnt - wr_b, 4);
        check("t1_acks", ack_cyc.size() - ack_b, 4);
        if (ack_cyc.size() - ack_b == 4) check("t1_ack_consec", ack_cyc[ack_b + 3] - ack_cyc[ack_b], 3);
        check("t1_pops", pop_cyc.size() - pop_b, 2);
        if (rd_log.size() > rd_b) check("t1_done_lat", done_cyc, rd_cyc[rd_cyc.size() - 1] + 1);
        check("t1_occ", dut.occ, 2);
        @(posedge i_clk); #1;
        check("t1_idle", {o_busy, o_done}, 0);

        // 2: win=2 pass=3 slides=1
        do_reset();
        start_job(2, 3, 1);
        wait_done();
        exp_q = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11};
        check_reads();
        check("t2_pops", pop_cyc.size() - pop_b, 1);
        check("t2_acks", ack_cyc.size() - ack_b, 2);

        // 3: full buffer with downstream held, win=12 slides=3
        do_reset();
        i_dn_hold = 1'b1;
        start_job(12, 1, 3);
        repeat (20) begin @(posedge i_clk); #1; end
        check("t3_acks_full", ack_cyc.size() - ack_b, 12);
        check("t3_ack_low_full", o_in_ack, 0);
        check("t3_no_read_held", o_read, 0);
        i_dn_hold = 1'b0;
        wait_done();
        check("t3_acks_total", ack_cyc.size() - ack_b, 14);
        check("t3_reads", rd_log.size() - rd_b, 36);
        check("t3_pops", pop_cyc.size() - pop_b, 3);
        if (ack_cyc.size() - ack_b > 12 && pop_cyc.size() > pop_b)
            check("t3_ack_after_pop", ack_cyc[ack_b + 12], pop_cyc[pop_b] + 1);

        // 4: duplicate entries 0 and 5
        do_reset();
        dup_mask = 32'b10_0001;
        start_job(3, 1, 4);
        wait_done();
        exp_q = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11,
                  2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
        check_reads();
        check("t4_acks", ack_cyc.size() - ack_b, 6);
        check("t4_writes", wr_cnt - wr_b, 4);
        check("t4_dups", dup_cnt - dup_b, 2);
        check("t4_occ", dut.occ, 2);

        // 5: hold for 3 cycles after the first read
        do_reset();
        start_job(3, 2, 1);
        wait_reads(1);
        i_dn_hold = 1'b1;
        repeat (3) begin @(posedge i_clk); #1; end
        i_dn_hold = 1'b0;
        wait_done();
        exp_q = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11};
        check_reads();
        if (rd_log.size() - rd_b >= 2) check("t5_gap", rd_cyc[rd_b + 1] - rd_cyc[rd_b], 4);

        // 6: reset mid-READ, then a single-entry job
        do_reset();
        start_job(3, 2, 1);
        wait_reads(2);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        check("t6_rst_outputs", {o_busy, o_done, o_read, o_pop, o_lastpix, o_write, o_dupWrite, o_in_ack}, 0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        start_job(1, 1, 1);
        wait_done();
        exp_q = '{2'b11};
        check_reads();
        check("t6_acks", ack_cyc.size() - ack_b, 1);
        if (rd_log.size() > rd_b) check("t6_done_lat", done_cyc, rd_cyc[rd_b] + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
